bcd_display_scanner: RTL



---
 rtl/display_pkg.sv | 41 ++++
 rtl/seven_seg_decoder.sv | 32 +++
 rtl/bcd_display_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int unsigned NumDigits = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef struct packed {
    logic                            neg;
    logic [NumDigits-1:0][3:0]       digits;
  } disp_t;

  // Index of the highest nonzero digit; 0 when every digit is zero.
  function automatic logic [2:0] msd_index(input logic [NumDigits-1:0][3:0] digits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NumDigits; i++) begin
      if (digits[i] != 4'd0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational 4-bit to active-low seven-segment glyph, hex digits A-F included.
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 8-digit common-anode display driver with a double-buffered
// snapshot, leading-zero blanking and a floating minus glyph.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_update,
  input  logic       i_neg,
  input  logic [3:0] i_first,
  input  logic [3:0] i_second,
  input  logic [3:0] i_third,
  input  logic [3:0] i_fourth,
  input  logic [3:0] i_fifth,
  input  logic [3:0] i_sixth,
  input  logic [3:0] i_seventh,
  input  logic [3:0] i_eighth,
  output logic [7:0] o_digit_en,
  output logic [6:0] o_seg,
  output logic       o_frame_done,
  output logic       o_sign_lost
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);

  logic [PrescW-1:0] r_presc;
  logic [2:0]        r_idx;
  disp_t             r_pend;
  disp_t             r_disp;
  logic              r_pend_valid;

  disp_t      w_in;
  logic       w_tc;
  logic       w_wrap;
  logic [2:0] w_msd;
  logic       w_nonzero;
  logic       w_neg_vis;
  logic [3:0] w_digit;
  logic [6:0] w_dec_seg;
  logic [6:0] w_glyph;

  assign w_in.neg    = i_neg;
  assign w_in.digits = {i_eighth, i_seventh, i_sixth, i_fifth,
                        i_fourth, i_third, i_second, i_first};

  assign w_tc   = (r_presc == PrescMax);
  assign w_wrap = w_tc && (r_idx == 3'd7);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A strobe landing on the commit cycle bypasses the pending buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend       <= '0;
      r_disp       <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_wrap) begin
      r_pend_valid <= 1'b0;
      if (i_update) begin
        r_disp <= w_in;
      end else if (r_pend_valid) begin
        r_disp <= r_pend;
      end
    end else if (i_update) begin
      r_pend       <= w_in;
      r_pend_valid <= 1'b1;
    end
  end

  assign w_msd     = msd_index(r_disp.digits);
  assign w_nonzero = |r_disp.digits;
  assign w_neg_vis = r_disp.neg && w_nonzero;
  assign w_digit   = r_disp.digits[r_idx];

  seven_seg_decoder u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec_seg)
  );

  always_comb begin
    w_glyph = w_dec_seg;
    if (BLANK_ZEROS && (r_idx > w_msd)) begin
      w_glyph = (w_neg_vis && (r_idx == w_msd + 3'd1)) ? SEG_MINUS : SEG_BLANK;
    end else if (!BLANK_ZEROS && w_neg_vis && (r_idx == 3'd7) && (w_msd != 3'd7)) begin
      w_glyph = SEG_MINUS;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_digit_en   <= 8'hFF;
      o_seg        <= SEG_BLANK;
      o_frame_done <= 1'b0;
      o_sign_lost  <= 1'b0;
    end else begin
      o_digit_en   <= ~(8'd1 << r_idx);
      o_seg        <= w_glyph;
      o_frame_done <= w_wrap;
      o_sign_lost  <= w_neg_vis && (w_msd == 3'd7);
    end
  end

endmodule
